fp_mul_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer that shares one combinational `FP_Mul` (IEEE-754 single-precision multiplier) between two requesters. It accepts an operand pair from the granted requester over a valid/ready handshake, registers the operands and the product, and returns the product on a response channel tagged with the requester ID. It sits between the FP ALU's multiply-issuing clients and the `FP_Mul` datapath.

---
 rtl/fp_alu_pkg.sv | 17 +
 rtl/FP_Mul.sv | 68 ++++++
 rtl/fp_mul_arbiter.sv | 120 ++++++++++++
 tb/tb_fp_mul_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fp_alu_pkg.sv
`default_nettype none
// ============================================================================
// fp_alu_pkg : shared constants and FSM encoding for the FP ALU controllers
// Rev 1.0
// ============================================================================
package fp_alu_pkg;

    localparam int FP_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/FP_Mul.sv
`default_nettype none
// ============================================================================
// FP_Mul : combinational IEEE-754 single multiply, round-to-nearest-even
// Rev 1.0
// ============================================================================
module FP_Mul
    import fp_alu_pkg::*;
(
    input  logic [FP_W-1:0] a_i,
    input  logic [FP_W-1:0] b_i,
    output logic [FP_W-1:0] p_o
);

    logic        sign;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [47:0] prod;
    logic [22:0] mant;
    logic        guard, sticky, round_up;
    logic [23:0] mant_r;
    logic [9:0]  exp_n, exp_r;

    assign sign   = a_i[31] ^ b_i[31];
    assign ea     = a_i[30:23];
    assign eb     = b_i[30:23];
    assign fa     = a_i[22:0];
    assign fb     = b_i[22:0];
    // Subnormal inputs are flushed to zero.
    assign a_zero = (ea == 8'd0);
    assign b_zero = (eb == 8'd0);
    assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);

    assign prod = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};

    always_comb begin
        if (prod[47]) begin
            mant   = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
        end else begin
            mant   = prod[45:23];
            guard  = prod[22];
            sticky = |prod[21:0];
        end
        round_up = guard & (sticky | mant[0]);
        mant_r   = {1'b0, mant} + {23'd0, round_up};
        // Two's-complement 10-bit biased exponent; bit 9 flags underflow.
        exp_n    = {2'b00, ea} + {2'b00, eb} + {9'd0, prod[47]} - 10'd127;
        exp_r    = exp_n + {9'd0, mant_r[23]};

        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
            p_o = 32'h7FC0_0000;
        else if (a_inf || b_inf)
            p_o = {sign, 8'hFF, 23'd0};
        else if (a_zero || b_zero || exp_r[9] || (exp_r == 10'd0))
            p_o = {sign, 31'd0};
        else if (exp_r >= 10'd255)
            p_o = {sign, 8'hFF, 23'd0};
        else
            p_o = {sign, exp_r[7:0], mant_r[22:0]};
    end

endmodule
`default_nettype wire

// File: rtl/fp_mul_arbiter.sv
`default_nettype none
// ============================================================================
// fp_mul_arbiter : two-port round-robin sequencer sharing one FP_Mul
// Rev 1.0
// ============================================================================
module fp_mul_arbiter
    import fp_alu_pkg::*;
#(
    parameter int W = FP_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         req1_ready,
    output logic         rsp_valid,
    output logic [W-1:0] rsp_data,
    output logic         rsp_id,
    input  logic         rsp_ready
);

    state_t         state_q, state_d;
    logic           last_q, last_d;
    logic [W-1:0]   op_a_q, op_a_d;
    logic [W-1:0]   op_b_q, op_b_d;
    logic           op_id_q, op_id_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [W-1:0]   rsp_data_q, rsp_data_d;
    logic           rsp_id_q, rsp_id_d;
    logic           grant;
    logic           accept;
    logic [W-1:0]   mul_p;

    // Grant is a pure function of the valids and the last pointer, so the
    // ready outputs never see rsp_ready.
    always_comb begin
        if (req0_valid && req1_valid) grant = ~last_q;
        else if (req1_valid)          grant = 1'b1;
        else if (req0_valid)          grant = 1'b0;
        else                          grant = ~last_q;
    end

    assign req0_ready = ~rst & (state_q == IDLE) & ~grant;
    assign req1_ready = ~rst & (state_q == IDLE) &  grant;
    assign accept     = grant ? (req1_valid & req1_ready) : (req0_valid & req0_ready);

    FP_Mul u_mul (
        .a_i (op_a_q),
        .b_i (op_b_q),
        .p_o (mul_p)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_id_d     = op_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EXEC;
                    last_d  = grant;
                    op_id_d = grant;
                    op_a_d  = grant ? req1_a : req0_a;
                    op_b_d  = grant ? req1_b : req0_b;
                end
            end
            EXEC: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = mul_p;
                rsp_id_d    = op_id_q;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_id_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_arbiter.sv
`default_nettype none
// ============================================================================
// tb_fp_mul_arbiter : directed bench for fp_mul_arbiter
// Rev 1.0
// ============================================================================
module tb_fp_mul_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_id;
    logic        rsp_ready;

    int vectors = 0;
    int errs    = 0;
    int seen;

    fp_mul_arbiter #(.W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_ready  (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data",  rsp_data, 32'h0);
        chk("rst_rsp_id",    {31'd0, rsp_id}, 32'd0);
        chk("rst_ready0",    {31'd0, req0_ready}, 32'd0);
        chk("rst_ready1",    {31'd0, req1_ready}, 32'd0);

        // Single multiply 2.5 * 4.0 on port 0
        rst = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        req0_a = 32'h4020_0000; req0_b = 32'h4080_0000;
        #1;
        chk("t1_ready0", {31'd0, req0_ready}, 32'd1);
        chk("t1_ready1", {31'd0, req1_ready}, 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("t1_exec_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t1_rsp_data",  rsp_data, 32'h4120_0000);
        chk("t1_rsp_id",    {31'd0, rsp_id}, 32'd0);
        @(negedge clk);
        chk("t1_rsp_done",  {31'd0, rsp_valid}, 32'd0);

        // Contention after reset: 0*4 on port 0, +Inf*4 on port 1
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 32'h0000_0000; req0_b = 32'h4080_0000;
        req1_valid = 1'b1; req1_a = 32'h7F80_0000; req1_b = 32'h4080_0000;
        #1;
        chk("c1_ready0", {31'd0, req0_ready}, 32'd1);
        chk("c1_ready1", {31'd0, req1_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("c1_rsp_data", rsp_data, 32'h0000_0000);
        chk("c1_rsp_id",   {31'd0, rsp_id}, 32'd0);
        @(negedge clk);
        chk("c2_ready1", {31'd0, req1_ready}, 32'd1);
        chk("c2_ready0", {31'd0, req0_ready}, 32'd0);
        @(negedge clk);
        req1_valid = 1'b0;
        req0_a = 32'h4020_0000; req0_b = 32'h4080_0000;
        @(negedge clk);
        chk("c2_rsp_data", rsp_data, 32'h7F80_0000);
        chk("c2_rsp_id",   {31'd0, rsp_id}, 32'd1);
        req1_valid = 1'b1;
        @(negedge clk);
        chk("c3_ready0", {31'd0, req0_ready}, 32'd1);
        chk("c3_ready1", {31'd0, req1_ready}, 32'd0);

        // Backpressure on the port 0 response, port 1 waiting
        @(negedge clk);
        req0_valid = 1'b0; rsp_ready = 1'b0;
        req1_a = 32'h436a_a666; req1_b = 32'hbe5e_353f;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_data",  rsp_data, 32'h4120_0000);
            chk("bp_rsp_id",    {31'd0, rsp_id}, 32'd0);
            chk("bp_ready0",    {31'd0, req0_ready}, 32'd0);
            chk("bp_ready1",    {31'd0, req1_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
        @(negedge clk);

        // Port 1 streaming, one grant every 3 cycles
        for (int k = 0; k < 3; k++) begin
            chk("st_idle_valid", {31'd0, rsp_valid}, 32'd0);
            chk("st_ready1",     {31'd0, req1_ready}, 32'd1);
            @(negedge clk);
            chk("st_exec_ready1", {31'd0, req1_ready}, 32'd0);
            @(negedge clk);
            chk("st_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("st_rsp_data",  rsp_data, 32'hC24B_AD1B);
            chk("st_rsp_id",    {31'd0, rsp_id}, 32'd1);
            @(negedge clk);
        end
        req1_valid = 1'b0;

        // Reset while port 0 operation is in EXEC
        req0_valid = 1'b1; req0_a = 32'h3F80_0000; req0_b = 32'hC000_0000;
        #1;
        chk("rm_ready0", {31'd0, req0_ready}, 32'd1);
        @(negedge clk);
        req0_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rm_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rm_rsp_data",  rsp_data, 32'h0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("rm_no_rsp", seen, 32'd0);

        // Contention after mid-op reset; port 1 then withdraws its valid
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rm_ready0", {31'd0, req0_ready}, 32'd1);
        chk("rm_ready1", {31'd0, req1_ready}, 32'd0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk("wd_rsp_data", rsp_data, 32'hC000_0000);
        chk("wd_rsp_id",   {31'd0, rsp_id}, 32'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid && rsp_id) seen++;
        end
        chk("wd_no_id1_rsp", seen, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
`default_nettype wire
